// File: rtl/match_controller_if.sv
// Bundles the frame-tick, button and ball-position inputs with the match status outputs.
interface match_controller_if;
  logic       update_screen;
  logic       arcade_button_pressed;
  logic [9:0] ball_left;
  logic       game_reset;
  logic       game_enable;
  logic       serve_right;
  logic [3:0] score_left;
  logic [3:0] score_right;
  logic [2:0] phase;
  logic       winner_right;

  // Driver side: game-state datapath / host.
  modport master (
    output update_screen,
    output arcade_button_pressed,
    output ball_left,
    input  game_reset,
    input  game_enable,
    input  serve_right,
    input  score_left,
    input  score_right,
    input  phase,
    input  winner_right
  );

  // Controller side.
  modport slave (
    input  update_screen,
    input  arcade_button_pressed,
    input  ball_left,
    output game_reset,
    output game_enable,
    output serve_right,
    output score_left,
    output score_right,
    output phase,
    output winner_right
  );
endinterface

// File: rtl/match_controller.sv
// Match sequencer for a two-player ball game: idle, serve delay, play, point delay,
// pause and game-over phases, with score keeping and serve direction.
module match_controller #(
  parameter int unsigned WIN_SCORE    = 7,
  parameter int unsigned SERVE_FRAMES = 120,
  parameter int unsigned POINT_FRAMES = 60,
  parameter logic [9:0]  LEFT_GOAL    = 10'd0,
  parameter logic [9:0]  RIGHT_GOAL   = 10'd632
) (
  input  logic              clock,
  input  logic              reset,
  match_controller_if.slave mc_io
);

  localparam logic [3:0] WinScore  = 4'(WIN_SCORE);
  localparam logic [7:0] ServeLoad = 8'(SERVE_FRAMES);
  localparam logic [7:0] PointLoad = 8'(POINT_FRAMES);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StServe = 3'd1,
    StPlay  = 3'd2,
    StPoint = 3'd3,
    StPause = 3'd4,
    StOver  = 3'd5
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] count_q, count_d;
  logic [3:0] score_left_q, score_left_d;
  logic [3:0] score_right_q, score_right_d;
  logic       serve_right_q, serve_right_d;
  logic       winner_right_q, winner_right_d;
  logic       game_reset_q, game_reset_d;
  logic       game_enable_q, game_enable_d;
  logic       button_prev_q, button_prev_d;

  logic press;
  logic tick;
  logic expire;
  logic left_missed;
  logic right_missed;

  // Saturating increment so a score can never wrap back to zero.
  function automatic logic [3:0] sat_inc(input logic [3:0] s);
    return (s == 4'hF) ? s : s + 4'd1;
  endfunction

  assign tick         = mc_io.update_screen;
  assign press        = mc_io.arcade_button_pressed & ~button_prev_q;
  // Expiry is the tick that takes the countdown from 1 to 0 (a stray 0 also expires).
  assign expire       = tick && (count_q <= 8'd1);
  assign left_missed  = mc_io.ball_left <= LEFT_GOAL;
  assign right_missed = mc_io.ball_left >= RIGHT_GOAL;

  // Next-state, countdown, score and registered-output computation.
  always_comb begin
    state_d        = state_q;
    count_d        = (tick && count_q != 8'd0) ? count_q - 8'd1 : count_q;
    score_left_d   = score_left_q;
    score_right_d  = score_right_q;
    serve_right_d  = serve_right_q;
    winner_right_d = winner_right_q;
    button_prev_d  = mc_io.arcade_button_pressed;

    case (state_q)
      StIdle: begin
        score_left_d  = 4'd0;
        score_right_d = 4'd0;
        if (press) begin
          state_d = StServe;
          count_d = ServeLoad;
        end
      end
      StServe: begin
        if (expire) state_d = StPlay;
      end
      StPlay: begin
        // A goal outranks a press landing in the same cycle.
        if (tick && left_missed) begin
          score_right_d = sat_inc(score_right_q);
          serve_right_d = 1'b0;
          state_d       = StPoint;
          count_d       = PointLoad;
        end else if (tick && right_missed) begin
          score_left_d  = sat_inc(score_left_q);
          serve_right_d = 1'b1;
          state_d       = StPoint;
          count_d       = PointLoad;
        end else if (press) begin
          state_d = StPause;
        end
      end
      StPause: begin
        if (press) state_d = StPlay;
      end
      StPoint: begin
        if (expire) begin
          if (score_left_q == WinScore || score_right_q == WinScore) begin
            state_d        = StOver;
            winner_right_d = (score_right_q == WinScore);
          end else begin
            state_d = StServe;
            count_d = ServeLoad;
          end
        end
      end
      StOver: begin
        if (press) begin
          state_d        = StServe;
          count_d        = ServeLoad;
          score_left_d   = 4'd0;
          score_right_d  = 4'd0;
          serve_right_d  = 1'b0;
          winner_right_d = 1'b0;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Control outputs follow the state being entered so they switch with phase.
    game_reset_d  = (state_d == StIdle) || (state_d == StServe) || (state_d == StOver);
    game_enable_d = (state_d == StPlay);
  end

  // State and output registers; synchronous reset wins over every event.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= StIdle;
      count_q        <= 8'd0;
      score_left_q   <= 4'd0;
      score_right_q  <= 4'd0;
      serve_right_q  <= 1'b0;
      winner_right_q <= 1'b0;
      game_reset_q   <= 1'b1;
      game_enable_q  <= 1'b0;
      button_prev_q  <= 1'b1;
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      score_left_q   <= score_left_d;
      score_right_q  <= score_right_d;
      serve_right_q  <= serve_right_d;
      winner_right_q <= winner_right_d;
      game_reset_q   <= game_reset_d;
      game_enable_q  <= game_enable_d;
      button_prev_q  <= button_prev_d;
    end
  end

  assign mc_io.phase        = state_q;
  assign mc_io.game_reset   = game_reset_q;
  assign mc_io.game_enable  = game_enable_q;
  assign mc_io.serve_right  = serve_right_q;
  assign mc_io.score_left   = score_left_q;
  assign mc_io.score_right  = score_right_q;
  assign mc_io.winner_right = winner_right_q;

endmodule

// File: tb/tb_match_controller.sv
// Scoreboard bench: stimulus queues each expected output snapshot, a monitor compares
// every change of the DUT outputs against the queue head.
module tb_match_controller;

  logic clock;
  logic reset;

  match_controller_if mc_if ();

  match_controller #(
    .WIN_SCORE   (2),
    .SERVE_FRAMES(3),
    .POINT_FRAMES(2)
  ) dut (
    .clock(clock),
    .reset(reset),
    .mc_io(mc_if)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [14:0] snap;
    string       name;
  } exp_t;

  exp_t        exp_q[$];
  int          errors = 0;
  int          checks = 0;
  bit          mon_en = 1'b0;
  logic [14:0] last_snap = 'x;

  // Snapshot of all outputs; winner_right only matters in OVER.
  function automatic logic [14:0] mk(input logic [2:0] ph, input logic gr, input logic ge,
                                     input logic sr, input logic [3:0] sl,
                                     input logic [3:0] srt, input logic wr);
    return {ph, gr, ge, sr, sl, srt, (ph == 3'd5) ? wr : 1'b0};
  endfunction

  task automatic expect_state(input string nm, input logic [14:0] s);
    exp_t e;
    e.snap = s;
    e.name = nm;
    exp_q.push_back(e);
  endtask

  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  // One frame tick followed by three quiet cycles, optionally with a press on the tick.
  task automatic tick(input logic with_press);
    mc_if.update_screen = 1'b1;
    if (with_press) mc_if.arcade_button_pressed = 1'b1;
    cycle();
    mc_if.update_screen         = 1'b0;
    mc_if.arcade_button_pressed = 1'b0;
    repeat (3) cycle();
  endtask

  task automatic press();
    mc_if.arcade_button_pressed = 1'b1;
    cycle();
    mc_if.arcade_button_pressed = 1'b0;
    cycle();
  endtask

  // Monitor: every change of the output snapshot must match the next expected entry.
  always @(negedge clock) begin
    logic [14:0] snap;
    exp_t        e;
    if (mon_en) begin
      snap = mk(mc_if.phase, mc_if.game_reset, mc_if.game_enable, mc_if.serve_right,
                mc_if.score_left, mc_if.score_right, mc_if.winner_right);
      if (snap !== last_snap) begin
        last_snap = snap;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change got=%h (no change expected)", snap);
        end else begin
          e = exp_q.pop_front();
          if (snap !== e.snap) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", e.name, snap, e.snap);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset                       = 1'b1;
    mc_if.update_screen         = 1'b0;
    mc_if.arcade_button_pressed = 1'b1;
    mc_if.ball_left             = 10'd320;

    // Reset with the button held: IDLE, no press on release of reset.
    expect_state("reset_idle", mk(3'd0, 1, 0, 0, 4'd0, 4'd0, 0));
    cycle();
    mon_en = 1'b1;
    cycle();
    reset = 1'b0;
    repeat (3) cycle();
    mc_if.arcade_button_pressed = 1'b0;
    repeat (2) cycle();
    tick(1'b0);

    // Press leaves IDLE; SERVE lasts three ticks and ignores presses.
    expect_state("idle_to_serve", mk(3'd1, 1, 0, 0, 4'd0, 4'd0, 0));
    press();
    tick(1'b0);
    press();
    tick(1'b0);
    expect_state("serve_to_play", mk(3'd2, 0, 1, 0, 4'd0, 4'd0, 0));
    tick(1'b0);

    // Ball at a goal without a tick does nothing; mid-field tick does nothing.
    mc_if.ball_left = 10'd0;
    repeat (6) cycle();
    mc_if.ball_left = 10'd320;
    tick(1'b0);

    // Right side misses: left scores, serve toward right.
    mc_if.ball_left = 10'd640;
    expect_state("left_point1", mk(3'd3, 0, 0, 1, 4'd1, 4'd0, 0));
    tick(1'b0);
    mc_if.ball_left = 10'd0;
    press();
    tick(1'b0);
    expect_state("point_to_serve", mk(3'd1, 1, 0, 1, 4'd1, 4'd0, 0));
    tick(1'b0);
    mc_if.ball_left = 10'd320;
    tick(1'b0);
    tick(1'b0);
    expect_state("serve_to_play2", mk(3'd2, 0, 1, 1, 4'd1, 4'd0, 0));
    tick(1'b0);

    // Right-goal boundary exactly at 632: second left point ends the match.
    mc_if.ball_left = 10'd632;
    expect_state("left_point2", mk(3'd3, 0, 0, 1, 4'd2, 4'd0, 0));
    tick(1'b0);
    mc_if.ball_left = 10'd320;
    tick(1'b0);
    expect_state("over_left_wins", mk(3'd5, 1, 0, 1, 4'd2, 4'd0, 0));
    tick(1'b0);
    tick(1'b0);
    expect_state("over_to_serve", mk(3'd1, 1, 0, 0, 4'd0, 4'd0, 0));
    press();
    tick(1'b0);
    tick(1'b0);
    expect_state("serve_to_play3", mk(3'd2, 0, 1, 0, 4'd0, 4'd0, 0));
    tick(1'b0);

    // Pause freezes goal checks; press resumes.
    expect_state("play_to_pause", mk(3'd4, 0, 0, 0, 4'd0, 4'd0, 0));
    press();
    mc_if.ball_left = 10'd0;
    tick(1'b0);
    tick(1'b0);
    expect_state("pause_to_play", mk(3'd2, 0, 1, 0, 4'd0, 4'd0, 0));
    press();

    // Goal and press on the same tick: the goal wins.
    expect_state("goal_over_press", mk(3'd3, 0, 0, 0, 4'd0, 4'd1, 0));
    tick(1'b1);
    mc_if.ball_left = 10'd320;
    tick(1'b0);

    // Reset mid-POINT together with a tick and a press.
    expect_state("reset_mid_point", mk(3'd0, 1, 0, 0, 4'd0, 4'd0, 0));
    reset                       = 1'b1;
    mc_if.update_screen         = 1'b1;
    mc_if.arcade_button_pressed = 1'b1;
    cycle();
    reset                       = 1'b0;
    mc_if.update_screen         = 1'b0;
    mc_if.arcade_button_pressed = 1'b0;
    repeat (3) cycle();

    // Right player wins a full match.
    expect_state("idle_to_serve2", mk(3'd1, 1, 0, 0, 4'd0, 4'd0, 0));
    press();
    tick(1'b0);
    tick(1'b0);
    expect_state("serve_to_play4", mk(3'd2, 0, 1, 0, 4'd0, 4'd0, 0));
    tick(1'b0);
    mc_if.ball_left = 10'd0;
    expect_state("right_point1", mk(3'd3, 0, 0, 0, 4'd0, 4'd1, 0));
    tick(1'b0);
    mc_if.ball_left = 10'd320;
    tick(1'b0);
    expect_state("point_to_serve2", mk(3'd1, 1, 0, 0, 4'd0, 4'd1, 0));
    tick(1'b0);
    tick(1'b0);
    tick(1'b0);
    expect_state("serve_to_play5", mk(3'd2, 0, 1, 0, 4'd0, 4'd1, 0));
    tick(1'b0);
    mc_if.ball_left = 10'd0;
    expect_state("right_point2", mk(3'd3, 0, 0, 0, 4'd0, 4'd2, 0));
    tick(1'b0);
    mc_if.ball_left = 10'd320;
    tick(1'b0);
    expect_state("over_right_wins", mk(3'd5, 1, 0, 0, 4'd0, 4'd2, 1));
    tick(1'b0);
    repeat (8) cycle();

    // Every expected transition must have been seen.
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_expectations got=%0d exp=0 next=%s", exp_q.size(),
               exp_q[0].name);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/match_controller.md
MATCH_CONTROLLER -- requirements
Module: match_controller

Interface
REQ-001 SHALL have parameter WIN_SCORE, default 7, points needed to win (1..15).
REQ-002 SHALL have parameter SERVE_FRAMES, default 120, frame ticks spent in SERVE (1..255).
REQ-003 SHALL have parameter POINT_FRAMES, default 60, frame ticks spent in POINT (1..255).
REQ-004 SHALL have parameter LEFT_GOAL, default 10'd0, ball_left at/below this = left side missed.
REQ-005 SHALL have parameter RIGHT_GOAL, default 10'd632, ball_left at/above this = right side missed (LEFT_GOAL < RIGHT_GOAL).
REQ-006 SHALL have port clock  input  1  single system clock, all logic on rising edge.
REQ-007 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-008 SHALL have port update_screen  input  1  one-cycle frame-tick pulse.
REQ-009 SHALL have port arcade_button_pressed  input  1  button level, already synchronized to clock.
REQ-010 SHALL have port ball_left  input  10  ball x position from game-state datapath.
REQ-011 SHALL have port game_reset  output  1  holds game-state datapath in its reset (ball/paddles recentred).
REQ-012 SHALL have port game_enable  output  1  frame-tick gate; datapath advances only when high.
REQ-013 SHALL have port serve_right  output  1  1 = next serve travels toward right player.
REQ-014 SHALL have port score_left, score_right  output  4 each  player scores.
REQ-015 SHALL have port phase  output  3  IDLE=0, SERVE=1, PLAY=2, POINT=3, PAUSE=4, OVER=5.
REQ-016 SHALL have port winner_right  output  1  valid in OVER; 1 = right won.

Function
REQ-017 SHALL edge-detect the button: press = level high now and low previous cycle; press is a one-cycle internal event.
REQ-018 SHALL keep an 8-bit frame countdown, loaded on state entry, decremented only on update_screen.
REQ-019 SHALL make SERVE/POINT last exactly N update_screen pulses: on the pulse that takes the count from 1 to 0, the state changes on the next clock edge.
REQ-020 IDLE: game_reset=1, game_enable=0, scores held at 0; press -> SERVE (load SERVE_FRAMES).
REQ-021 SERVE: game_reset=1, game_enable=0; countdown expiry -> PLAY.
REQ-022 PLAY: game_reset=0, game_enable=1; goal check only in cycles with update_screen=1.
REQ-023 PLAY, update_screen and ball_left <= LEFT_GOAL: score_right+1, serve_right=0, -> POINT.
REQ-024 PLAY, update_screen and ball_left >= RIGHT_GOAL: score_left+1, serve_right=1, -> POINT.
REQ-025 PLAY, press with no goal in same cycle -> PAUSE; goal takes priority over a simultaneous press.
REQ-026 PAUSE: game_reset=0, game_enable=0 (frozen, no goal checks); press -> PLAY.
REQ-027 POINT: game_reset=0, game_enable=0; on expiry, if either score == WIN_SCORE -> OVER, else -> SERVE (load SERVE_FRAMES).
REQ-028 OVER: game_reset=1, game_enable=0, scores held; winner_right=(score_right==WIN_SCORE); press -> SERVE with both scores cleared to 0 and serve_right=0.
REQ-029 SHALL ignore presses in SERVE and POINT.
REQ-030 Scores SHALL change only on the REQ-023/024/028 events; no wrap (reach WIN_SCORE then OVER).
REQ-031 All outputs SHALL be registered; phase and control outputs change in the same cycle as the state register.
REQ-032 Unused phase encodings (6,7) SHALL recover to IDLE on the next edge.

Reset
REQ-033 On reset=1 at a clock edge: phase=IDLE, game_reset=1, game_enable=0, scores=0, serve_right=0, winner_right=0, countdown=0, previous-button register=1 (button held through reset is not a press).
REQ-034 Reset SHALL override all events in the same cycle, including mid-PLAY goals and presses.

Verification (WIN_SCORE=2, SERVE_FRAMES=3, POINT_FRAMES=2, update_screen every 4 cycles)
REQ-035 Reset with button held high, release, press -> IDLE holds until press, then phase=1; exactly 3 ticks later phase=2, game_enable=1, game_reset=0.
REQ-036 In PLAY, ball_left=640 on a tick -> score_left=1, serve_right=1, phase=3; after 2 ticks phase=1; ball_left=0 without tick -> no score change.
REQ-037 Left scores twice -> after second POINT expiry phase=5, winner_right=0, score_left=2; press -> phase=1, scores 0, serve_right=0.
REQ-038 Press in PLAY -> phase=4, game_enable=0, ball_left=0 on ticks ignored; press -> phase=2; goal and press in same tick cycle -> phase=3, score updated.
REQ-039 Assert reset mid-POINT with score_right=1 -> next cycle phase=0, scores 0, game_reset=1; presses during SERVE/POINT never alter phase.
